// File: rtl/tdc_ctrl_pkg.sv
// rtl/tdc_ctrl_pkg.sv - shared state encoding, control/status bit indices and sizing helper
package tdc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_RUN_DONE = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_CLR_DONE = 3'd4
    } state_t;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_CONT = 2;

    localparam int STAT_RDY  = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_WRAP = 2;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/tdc_sample_acc.sv
// rtl/tdc_sample_acc.sv - saturating sample accumulator with per-word sample counter
module tdc_sample_acc #(
    parameter int ONES_W   = 8,
    parameter int DATA_W   = 32,
    parameter int ACC_LOG2 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [ONES_W-1:0] ones,
    output logic              word_valid,
    output logic [DATA_W-1:0] word_data
);

    localparam int              CNT_W    = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << ACC_LOG2) - 1);

    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   sum;

    // One extra bit of headroom detects overflow; the word sticks at all-ones.
    always_comb begin
        sum        = {1'b0, acc} + (DATA_W+1)'(ones);
        word_data  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        word_valid = sample_en && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (sample_en) begin
            if (word_valid) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= word_data;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_capture_ctrl.sv
// rtl/tdc_capture_ctrl.sv - TDC popcount capture into BRAM port B with clear sweep and Booth finish flag
module tdc_capture_ctrl
    import tdc_ctrl_pkg::*;
#(
    parameter int ONES_W   = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 15,
    parameter int DEPTH    = 8192,
    parameter int ACC_LOG2 = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ONES_W-1:0]     ones,
    input  logic [2:0]            ctrl,
    output logic [2:0]            status,
    output logic                  finish,
    output logic                  clkb,
    output logic                  rstb,
    output logic                  enb,
    output logic [DATA_W/8-1:0]   web,
    output logic [ADDR_W-1:0]     addrb,
    output logic [DATA_W-1:0]     datab
);

    localparam int             BYTES    = bytes_per_word(DATA_W);
    localparam int             BYTE_SH  = $clog2(BYTES);
    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic               cont_q, cont_nxt;
    logic               full_q, full_nxt;
    logic               wrap_q, wrap_nxt;
    logic               finish_nxt;
    logic               wr;
    logic [DATA_W-1:0]  wr_data;
    logic               sample_en, acc_clear;
    logic               word_valid;
    logic [DATA_W-1:0]  word_data;

    // Kept outside the FSM process so word_valid never feeds back into its own driver.
    assign sample_en = (state == ST_RUN) && ctrl[CTRL_RUN];
    assign acc_clear = (state != ST_RUN);

    tdc_sample_acc #(
        .ONES_W   (ONES_W),
        .DATA_W   (DATA_W),
        .ACC_LOG2 (ACC_LOG2)
    ) u_acc (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .clear      (acc_clear),
        .sample_en  (sample_en),
        .ones       (ones),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cont_nxt   = cont_q;
        full_nxt   = full_q;
        wrap_nxt   = wrap_q;
        finish_nxt = finish;
        wr         = 1'b0;
        wr_data    = '0;
        case (state)
            ST_IDLE: begin
                ptr_nxt = '0;
                if (ctrl[CTRL_CLR]) begin
                    state_nxt  = ST_CLEAR;
                    finish_nxt = 1'b1;
                    full_nxt   = 1'b1;
                end else if (ctrl[CTRL_RUN]) begin
                    state_nxt  = ST_RUN;
                    finish_nxt = 1'b0;
                    cont_nxt   = ctrl[CTRL_CONT];
                end
            end
            ST_RUN: begin
                if (!ctrl[CTRL_RUN]) begin
                    state_nxt = ST_RUN_DONE;
                end else if (word_valid) begin
                    wr      = 1'b1;
                    wr_data = word_data;
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        ptr_nxt = '0;
                        if (cont_q) begin
                            wrap_nxt = 1'b1;
                        end else begin
                            full_nxt  = 1'b1;
                            state_nxt = ST_RUN_DONE;
                        end
                    end
                end
            end
            ST_RUN_DONE: begin
                if (!ctrl[CTRL_RUN]) state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                wr      = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (ptr == PTR_LAST) begin
                    ptr_nxt   = '0;
                    state_nxt = ST_CLR_DONE;
                    full_nxt  = 1'b0;
                    wrap_nxt  = 1'b0;
                end
            end
            ST_CLR_DONE: begin
                if (!ctrl[CTRL_CLR]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            cont_q <= 1'b0;
            full_q <= 1'b0;
            wrap_q <= 1'b0;
            finish <= 1'b0;
            enb    <= 1'b0;
            addrb  <= '0;
            datab  <= '0;
            status <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cont_q <= cont_nxt;
            full_q <= full_nxt;
            wrap_q <= wrap_nxt;
            finish <= finish_nxt;
            enb    <= wr;
            datab  <= wr_data;
            if (wr) addrb <= ADDR_W'(ptr) << BYTE_SH;
            status[STAT_RDY]  <= (state == ST_IDLE);
            status[STAT_FULL] <= full_q;
            status[STAT_WRAP] <= wrap_q;
        end
    end

    assign web  = {BYTES{enb}};
    assign clkb = sys_clk;
    assign rstb = 1'b0;

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// tb/tb_tdc_capture_ctrl.sv - randomized self-checking bench for tdc_capture_ctrl (raw and accumulating instances)
module tb_tdc_capture_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] ones = 8'd0;
    logic [2:0] ctrl = 3'd0;
    logic       sel = 1'b0;
    logic [2:0] a_ctrl, b_ctrl;

    always #5 sys_clk = ~sys_clk;

    assign a_ctrl = sel ? 3'd0 : ctrl;
    assign b_ctrl = sel ? ctrl : 3'd0;

    logic [2:0]  a_status, b_status;
    logic        a_finish, b_finish, a_clkb, b_clkb, a_rstb, b_rstb, a_enb, b_enb;
    logic [3:0]  a_web;
    logic [0:0]  b_web;
    logic [14:0] a_addrb;
    logic [5:0]  b_addrb;
    logic [31:0] a_datab;
    logic [7:0]  b_datab;

    tdc_capture_ctrl #(.ONES_W(8), .DATA_W(32), .ADDR_W(15), .DEPTH(16), .ACC_LOG2(0)) u_raw (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ones(ones), .ctrl(a_ctrl),
        .status(a_status), .finish(a_finish), .clkb(a_clkb), .rstb(a_rstb),
        .enb(a_enb), .web(a_web), .addrb(a_addrb), .datab(a_datab));

    tdc_capture_ctrl #(.ONES_W(8), .DATA_W(8), .ADDR_W(6), .DEPTH(8), .ACC_LOG2(2)) u_acc4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ones(ones), .ctrl(b_ctrl),
        .status(b_status), .finish(b_finish), .clkb(b_clkb), .rstb(b_rstb),
        .enb(b_enb), .web(b_web), .addrb(b_addrb), .datab(b_datab));

    logic [31:0] obs_data, obs_addr;
    logic        obs_enb, obs_finish;
    logic [2:0]  obs_status;
    logic [3:0]  obs_web;

    always_comb begin
        if (sel) begin
            obs_enb = b_enb; obs_web = {3'b0, b_web}; obs_addr = {26'b0, b_addrb};
            obs_data = {24'b0, b_datab}; obs_status = b_status; obs_finish = b_finish;
        end else begin
            obs_enb = a_enb; obs_web = a_web; obs_addr = {17'b0, a_addrb};
            obs_data = a_datab; obs_status = a_status; obs_finish = a_finish;
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          samples[$];
    bit          full_m[2], wrap_m[2], finish_m[2];
    logic [31:0] mem_obs[16];

    // Mirror of the raw instance's BRAM, built from the writes it issues.
    always @(negedge sys_clk) begin
        if (sys_rst_n && !sel && a_enb) mem_obs[a_addrb[5:2]] <= a_datab;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_of();     return sel ? 4 : 1;  endfunction
    function automatic int depth_of(); return sel ? 8 : 16; endfunction
    function automatic int bytes_of(); return sel ? 1 : 4;  endfunction

    function automatic logic [7:0] gen(input int pat, input int j);
        case (pat)
            0:       return 8'(j);
            1:       return 8'd3;
            2:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Sample j is driven on the (j+1)-th falling edge after run; word w appears one cycle after its last sample.
    task automatic capture(input int nwords, input bit cont, input int pat, input bit hold_run);
        int m, dep, nsmp, w;
        longint sum, maxv;
        bit exp_wr;
        logic [7:0] s;
        m = m_of(); dep = depth_of(); nsmp = nwords * m;
        maxv = sel ? 64'd255 : 64'hFFFF_FFFF;
        samples.delete();
        @(negedge sys_clk);
        ctrl = {cont, 1'b0, 1'b1};
        for (int k = 1; k <= nsmp + 1; k++) begin
            @(negedge sys_clk);
            exp_wr = (k >= 2) && (((k - 1) % m) == 0);
            check("enb", {31'b0, obs_enb}, {31'b0, exp_wr});
            check("web", {28'b0, obs_web}, exp_wr ? (sel ? 32'h1 : 32'hF) : 32'h0);
            if (exp_wr) begin
                w = (k - 1) / m - 1;
                sum = 0;
                for (int j = 0; j < m; j++) sum += longint'(samples[w * m + j]);
                if (sum > maxv) sum = maxv;
                check("datab", obs_data, 32'(sum));
                check("addrb", obs_addr, 32'((w % dep) * bytes_of()));
            end
            if (k == 3) check("run_rdy", {31'b0, obs_status[0]}, 32'd0);
            if (k <= nsmp) begin
                s = gen(pat, k - 1);
                ones = s;
                samples.push_back(int'(s));
            end
        end
        if (!cont && nwords == dep) full_m[sel] = 1'b1;
        if (cont && nwords > dep)   wrap_m[sel] = 1'b1;
        finish_m[sel] = 1'b0;
        if (hold_run) begin
            repeat (3) begin
                @(negedge sys_clk);
                check("done_enb", {31'b0, obs_enb}, 32'd0);
                check("done_datab", obs_data, 32'd0);
            end
            check("done_rdy", {31'b0, obs_status[0]}, 32'd0);
        end
        ctrl = 3'd0;
        repeat (4) begin
            @(negedge sys_clk);
            check("idle_enb", {31'b0, obs_enb}, 32'd0);
        end
        check("status", {29'b0, obs_status}, {29'b0, wrap_m[sel], full_m[sel], 1'b1});
        check("finish", {31'b0, obs_finish}, {31'b0, finish_m[sel]});
    endtask

    task automatic clear(input bit with_run);
        int dep;
        bit exp_wr;
        dep = depth_of();
        @(negedge sys_clk);
        ctrl = with_run ? 3'b011 : 3'b010;
        for (int k = 1; k <= dep + 3; k++) begin
            @(negedge sys_clk);
            exp_wr = (k >= 2) && (k <= dep + 1);
            check("clr_enb", {31'b0, obs_enb}, {31'b0, exp_wr});
            if (exp_wr) begin
                check("clr_addr", obs_addr, 32'((k - 2) * bytes_of()));
                check("clr_data", obs_data, 32'd0);
            end
            if (k == 2) check("clr_finish", {31'b0, obs_finish}, 32'd1);
            if (k == 3) check("clr_full", {31'b0, obs_status[1]}, 32'd1);
        end
        full_m[sel] = 1'b0; wrap_m[sel] = 1'b0; finish_m[sel] = 1'b1;
        ctrl = 3'd0;
        repeat (4) @(negedge sys_clk);
        check("clr_status", {29'b0, obs_status}, 32'b001);
        check("clr_finish_hold", {31'b0, obs_finish}, 32'd1);
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_enb",    {31'b0, a_enb},    32'd0);
        check("rst_web",    {28'b0, a_web},    32'd0);
        check("rst_addrb",  {17'b0, a_addrb},  32'd0);
        check("rst_datab",  a_datab,           32'd0);
        check("rst_status", {29'b0, a_status}, 32'd0);
        check("rst_finish", {31'b0, a_finish}, 32'd0);
        check("rst_b_enb",  {31'b0, b_enb},    32'd0);
        check("rst_b_stat", {29'b0, b_status}, 32'd0);
        check("rstb",       {30'b0, a_rstb, b_rstb}, 32'd0);
        check("clkb",       {30'b0, a_clkb, b_clkb}, {30'b0, sys_clk, sys_clk});
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("idle_status", {29'b0, a_status}, 32'b001);

        // raw instance: ramp single-shot, clear, ring, clear with run, abort
        capture(16, 1'b0, 0, 1'b1);
        clear(1'b0);
        capture(20, 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) check("ring_word", mem_obs[i], 32'(16 + i));
        check("ring_word4", mem_obs[4], 32'd4);
        clear(1'b1);
        capture(5, 1'b0, 3, 1'b0);

        // asynchronous reset in the middle of a run
        @(negedge sys_clk);
        ctrl = 3'b001; ones = 8'h5a;
        repeat (6) @(negedge sys_clk);
        check("pre_rst_enb", {31'b0, a_enb}, 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_enb",    {31'b0, a_enb},    32'd0);
        check("mid_rst_addrb",  {17'b0, a_addrb},  32'd0);
        check("mid_rst_datab",  a_datab,           32'd0);
        check("mid_rst_status", {29'b0, a_status}, 32'd0);
        @(negedge sys_clk);
        ctrl = 3'd0;
        sys_rst_n = 1'b1;
        full_m = '{1'b0, 1'b0}; wrap_m = '{1'b0, 1'b0}; finish_m = '{1'b0, 1'b0};
        capture(16, 1'b0, 3, 1'b1);

        // accumulating 8-bit instance: constant, saturation, random, ring
        @(negedge sys_clk);
        sel = 1'b1;
        capture(8, 1'b0, 1, 1'b1);
        clear(1'b0);
        capture(8, 1'b0, 2, 1'b1);
        clear(1'b0);
        capture(8, 1'b0, 3, 1'b1);
        capture(12, 1'b1, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
